alu_control_muldiv: RTL and testbench
=====================================

// Module: alu_control_muldiv
// PURPOSE
//  Next-generation ALU control for the MIPS core: decodes ALUOp/Funct into a 4-bit ALUControl
//  with an extended R-type set, and owns an iterative multiply/divide engine with HI/LO registers.
//  Drives Stall to freeze PC and register-file writes while MULTU/DIVU run or MFHI/MFLO must wait.
//  Sits between the main control decoder, the datapath ALU and the writeback mux.
// PARAMETERS
//  WIDTH   32  operand width; HI and LO are each WIDTH bits
//  CNT_W   6   iteration-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk         in   1        core clock
//  reset       in   1        synchronous, active-high
//  InstrValid  in   1        current instruction is valid (not a bubble)
//  ALUOp       in   2        00 add, 01 sub, 10 R-type (Funct), 11 illegal
//  Funct       in   6        instruction function field
//  SrcA        in   WIDTH    rs value
//  SrcB        in   WIDTH    rt value
//  ALUControl  out  4        0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT, 1100 NOR, 1111 SLTU
//  Illegal     out  1        unsupported ALUOp/Funct combination
//  Stall       out  1        hold PC and suppress register writes this cycle
//  HiLoWrite   out  1        MFHI/MFLO result selected for writeback
//  HiLoOut     out  WIDTH    HI for MFHI, LO for MFLO, else 0
//  DivByZero   out  1        sticky; set by DIVU with SrcB==0, cleared by the next MULTU/DIVU start
// BEHAVIOUR
//  Decode is combinational. ALUOp 00->ADD, 01->SUB, 11->ADD with Illegal=1.
//  ALUOp 10 Funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR,
//   101010 SLT, 101011 SLTU. MULTU 011001, DIVU 011011, MFHI 010000, MFLO 010010 set ALUControl=ADD.
//   Any other Funct gives ADD with Illegal=1. No latches: every path assigns every output.
//  FSM states IDLE, MUL, DIV, DONE; reset -> IDLE, HI=LO=0, counter=0, DivByZero=0, Stall=0.
//  IDLE: InstrValid & MULTU -> MUL, or InstrValid & DIVU -> DIV. SrcA/SrcB are latched and Stall=1 in the
//   start cycle. counter loads WIDTH-1.
//  MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator. DIV: restoring, one quotient bit per cycle.
//   Stall=1 throughout. At counter==0, HI/LO are written on that edge and the FSM moves to DONE.
//   MULTU writes HI:LO = SrcA*SrcB. DIVU writes LO = quotient and HI = remainder.
//  DONE: Stall=0 for one cycle so the stalled MULTU/DIVU retires. No restart is allowed in DONE, even if start
//   conditions hold. The FSM then returns to IDLE.
//  Latency: start cycle plus WIDTH compute cycles, so Stall is high for WIDTH+1 cycles. HI/LO are valid from DONE.
//  DIVU with SrcB==0: the engine is bypassed. LO = all ones, HI = SrcA, DivByZero = 1, and the FSM goes
//   straight to DONE, so Stall is high for 1 cycle.
//  MFHI/MFLO: HiLoWrite=1 and HiLoOut is HI or LO. If the FSM is in MUL or DIV, Stall=1 until DONE, where the
//   new value is returned.
//  InstrValid=0: no start and no stall. Stall from an in-flight op persists regardless of InstrValid.
//  Synchronous reset mid-operation: abort to IDLE, HI and LO cleared, and Stall low in the following cycle.
// CONFIGURATION
//  SIGNED_MULDIV_EN defined: also decodes MULT 011000 and DIV 011010. Operands are converted to magnitudes at start
//   and results are sign-corrected in DONE's preceding edge. Remainder takes the dividend's sign, and the quotient
//   truncates toward zero. Signed divide-by-zero follows the same rule as DIVU.
//  Undefined: 011000/011010 give Illegal=1, no start, and no stall.
// STRUCTURE
//  Package alu_ctrl_pkg holds the ALUControl codes, Funct codes, ALUOp codes and the FSM state enum.
//  One sub-module, muldiv_iter, contains the accumulator, counter and shift/subtract datapath. The top level keeps
//   the decode, FSM, HI/LO and Stall logic.
// TESTING
//  ALUOp=10 sweeping all Funct codes -> the ALUControl table above, and Illegal=1 exactly for unlisted codes
//   (e.g. 000000).
//  MULTU 0xFFFFFFFF*0x2 -> Stall high for 33 cycles, then HI=0x1, LO=0xFFFFFFFE. MFLO next -> HiLoOut=0xFFFFFFFE.
//  DIVU 100/7 -> LO=14, HI=2 after 33 stall cycles. MFHI issued during the op stalls, then returns 2.
//  DIVU 5/0 -> 1 stall cycle, LO=0xFFFFFFFF, HI=5, DivByZero=1. The next MULTU start clears DivByZero.
//  Reset asserted at compute cycle 10 of MULTU -> next cycle Stall=0, HI=LO=0, FSM in IDLE.
//  With SIGNED_MULDIV_EN: DIV -7/2 -> LO=-3, HI=-1. MULT -3*4 -> HI:LO=-12. Without it, MULT -> Illegal=1, Stall=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control / multiply-divide block: ALUControl codes,
// ALUOp codes, Funct codes and the engine FSM state constants.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per cycle,
// sharing one 2*WIDTH accumulator (upper = partial product / remainder, lower = multiplier / quotient).
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             cnt_zero,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [WIDTH-1:0] upper, lower, operand;
  logic [WIDTH-1:0] upper_nxt, lower_nxt;
  logic [WIDTH:0]   sum, trial;
  logic [CNT_W-1:0] count;

  // Results are the next accumulator value so the top can capture them on the final edge.
  always_comb begin
    sum   = {1'b0, upper} + {1'b0, (lower[0] ? operand : {WIDTH{1'b0}})};
    trial = {upper, lower[WIDTH-1]} - {1'b0, operand};
    if (is_div) begin
      if (!trial[WIDTH]) begin
        upper_nxt = trial[WIDTH-1:0];
        lower_nxt = {lower[WIDTH-2:0], 1'b1};
      end else begin
        upper_nxt = {upper[WIDTH-2:0], lower[WIDTH-1]};
        lower_nxt = {lower[WIDTH-2:0], 1'b0};
      end
    end else begin
      upper_nxt = sum[WIDTH:1];
      lower_nxt = {sum[0], lower[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upper   <= '0;
      lower   <= '0;
      operand <= '0;
      count   <= '0;
    end else if (load) begin
      upper   <= '0;
      lower   <= opa;
      operand <= opb;
      count   <= CNT_W'(WIDTH - 1);
    end else if (run) begin
      upper <= upper_nxt;
      lower <= lower_nxt;
      if (count != '0) count <= count - 1'b1;
    end
  end

  assign cnt_zero = (count == '0);
  assign res_hi   = upper_nxt;
  assign res_lo   = lower_nxt;

endmodule

// File: rtl/alu_control_muldiv.sv
// ALU control decode plus multiply/divide FSM with HI/LO and pipeline stall.
// Define SIGNED_MULDIV_EN to also accept signed MULT/DIV.
module alu_control_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InstrValid,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [3:0]       ALUControl,
  output logic             Illegal,
  output logic             Stall,
  output logic             HiLoWrite,
  output logic [WIDTH-1:0] HiLoOut,
  output logic             DivByZero
);

  import alu_ctrl_pkg::*;

  logic [1:0]         state;
  logic [WIDTH-1:0]   hi, lo;
  logic               neg_lo, neg_hi;
  logic               dec_multu, dec_divu, dec_mult, dec_div, dec_mfhi, dec_mflo;
  logic               signed_op, start_mul, start_div, start, div_zero;
  logic [WIDTH-1:0]   mag_a, mag_b, res_hi, res_lo, fin_hi, fin_lo;
  logic [2*WIDTH-1:0] prod;
  logic               cnt_zero;

  always_comb begin
    ALUControl = ALU_ADD;
    Illegal    = 1'b0;
    dec_multu  = 1'b0;
    dec_divu   = 1'b0;
    dec_mult   = 1'b0;
    dec_div    = 1'b0;
    dec_mfhi   = 1'b0;
    dec_mflo   = 1'b0;
    case (ALUOp)
      ALUOP_ADD:   ALUControl = ALU_ADD;
      ALUOP_SUB:   ALUControl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (Funct)
          F_ADD:   ALUControl = ALU_ADD;
          F_SUB:   ALUControl = ALU_SUB;
          F_AND:   ALUControl = ALU_AND;
          F_OR:    ALUControl = ALU_OR;
          F_XOR:   ALUControl = ALU_XOR;
          F_NOR:   ALUControl = ALU_NOR;
          F_SLT:   ALUControl = ALU_SLT;
          F_SLTU:  ALUControl = ALU_SLTU;
          F_MULTU: dec_multu  = 1'b1;
          F_DIVU:  dec_divu   = 1'b1;
          F_MFHI:  dec_mfhi   = 1'b1;
          F_MFLO:  dec_mflo   = 1'b1;
`ifdef SIGNED_MULDIV_EN
          F_MULT:  dec_mult   = 1'b1;
          F_DIV:   dec_div    = 1'b1;
`endif
          default: Illegal    = 1'b1;
        endcase
      end
      default:     Illegal    = 1'b1;
    endcase
  end

  assign signed_op = dec_mult | dec_div;
  assign start_mul = InstrValid && (state == ST_IDLE) && (dec_multu || dec_mult);
  assign start_div = InstrValid && (state == ST_IDLE) && (dec_divu || dec_div);
  assign start     = start_mul | start_div;
  assign div_zero  = start_div && (SrcB == '0);
  assign mag_a     = (signed_op && SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign mag_b     = (signed_op && SrcB[WIDTH-1]) ? -SrcB : SrcB;

  muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (start && !div_zero),
    .run      ((state == ST_MUL) || (state == ST_DIV)),
    .is_div   (state == ST_DIV),
    .opa      (mag_a),
    .opb      (mag_b),
    .cnt_zero (cnt_zero),
    .res_hi   (res_hi),
    .res_lo   (res_lo)
  );

  // Sign correction applied to the engine's final magnitude results.
  always_comb begin
    prod = {res_hi, res_lo};
    if (neg_lo) prod = -prod;
    fin_hi = prod[2*WIDTH-1:WIDTH];
    fin_lo = prod[WIDTH-1:0];
    if (state == ST_DIV) begin
      fin_lo = neg_lo ? -res_lo : res_lo;
      fin_hi = neg_hi ? -res_hi : res_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      hi        <= '0;
      lo        <= '0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            DivByZero <= 1'b0;
            neg_lo    <= signed_op && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            neg_hi    <= signed_op && start_div && SrcA[WIDTH-1];
            if (div_zero) begin
              lo        <= '1;
              hi        <= SrcA;
              DivByZero <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= start_mul ? ST_MUL : ST_DIV;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_zero) begin
            hi    <= fin_hi;
            lo    <= fin_lo;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // MFHI/MFLO issued mid-operation are covered because MUL/DIV always stall.
  assign Stall     = start || (state == ST_MUL) || (state == ST_DIV);
  assign HiLoWrite = InstrValid && (dec_mfhi || dec_mflo);
  assign HiLoOut   = (InstrValid && dec_mfhi) ? hi :
                     (InstrValid && dec_mflo) ? lo : '0;

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Self-checking bench for alu_control_muldiv: decode table, Funct sweep and scoreboarded mul/div runs.
module tb_alu_control_muldiv;

  logic        clk;
  logic        reset;
  logic        InstrValid;
  logic [1:0]  ALUOp;
  logic [5:0]  Funct;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  ALUControl;
  logic        Illegal, Stall, HiLoWrite, DivByZero;
  logic [31:0] HiLoOut;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [3:0] ctrl;
    logic       ill;
  } dec_vec_t;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
    logic        dbz;
  } exp_t;

  dec_vec_t vecs[16];
  exp_t     sb[$];

  alu_control_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .InstrValid (InstrValid),
    .ALUOp      (ALUOp),
    .Funct      (Funct),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .Illegal    (Illegal),
    .Stall      (Stall),
    .HiLoWrite  (HiLoWrite),
    .HiLoOut    (HiLoOut),
    .DivByZero  (DivByZero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] aluop, input logic [5:0] funct,
                               input logic [31:0] a, input logic [31:0] b, input logic valid);
    ALUOp      = aluop;
    Funct      = funct;
    SrcA       = a;
    SrcB       = b;
    InstrValid = valid;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  // Start an op, optionally switch the held instruction after the start cycle, and
  // compare stall length, DivByZero and HI/LO against the scoreboard entry.
  task automatic runOp(input string name, input logic [5:0] funct, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                       input int stalls, input logic dbz, input logic [5:0] hold_funct);
    exp_t e;
    int   cnt;
    sb.push_back('{name, hi, lo, stalls, dbz});
    applyStimulus(2'b10, funct, a, b, 1'b1);
    cnt = 0;
    while (Stall === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
      if (cnt == 1) Funct = hold_funct;
      #1;
    end
    e = sb.pop_front();
    checkOutput({e.name, "_stall_cycles"}, 64'(cnt), 64'(e.stalls));
    checkOutput({e.name, "_divbyzero"}, 64'(DivByZero), 64'(e.dbz));
    if (hold_funct == 6'b010000) begin
      checkOutput({e.name, "_mfhi_in_done"}, 64'(HiLoOut), 64'(e.hi));
      checkOutput({e.name, "_hilowrite_in_done"}, 64'(HiLoWrite), 64'd1);
    end
    tick();
    applyStimulus(2'b10, 6'b010000, 32'h0, 32'h0, 1'b1);
    checkOutput({e.name, "_no_restart"}, 64'(Stall), 64'd0);
    checkOutput({e.name, "_hi"}, 64'(HiLoOut), 64'(e.hi));
    tick();
    applyStimulus(2'b10, 6'b010010, 32'h0, 32'h0, 1'b1);
    checkOutput({e.name, "_lo"}, 64'(HiLoOut), 64'(e.lo));
    tick();
  endtask

  initial begin
    logic [5:0] legal[$];
    logic       is_legal;

    vecs[0]  = '{2'b00, 6'b000000, 4'b0010, 1'b0};
    vecs[1]  = '{2'b01, 6'b000000, 4'b0110, 1'b0};
    vecs[2]  = '{2'b11, 6'b100100, 4'b0010, 1'b1};
    vecs[3]  = '{2'b10, 6'b100000, 4'b0010, 1'b0};
    vecs[4]  = '{2'b10, 6'b100010, 4'b0110, 1'b0};
    vecs[5]  = '{2'b10, 6'b100100, 4'b0000, 1'b0};
    vecs[6]  = '{2'b10, 6'b100101, 4'b0001, 1'b0};
    vecs[7]  = '{2'b10, 6'b100110, 4'b0011, 1'b0};
    vecs[8]  = '{2'b10, 6'b100111, 4'b1100, 1'b0};
    vecs[9]  = '{2'b10, 6'b101010, 4'b0111, 1'b0};
    vecs[10] = '{2'b10, 6'b101011, 4'b1111, 1'b0};
    vecs[11] = '{2'b10, 6'b011001, 4'b0010, 1'b0};
    vecs[12] = '{2'b10, 6'b011011, 4'b0010, 1'b0};
    vecs[13] = '{2'b10, 6'b010000, 4'b0010, 1'b0};
    vecs[14] = '{2'b10, 6'b010010, 4'b0010, 1'b0};
    vecs[15] = '{2'b10, 6'b000000, 4'b0010, 1'b1};

    legal = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
              6'b101010, 6'b101011, 6'b011001, 6'b011011, 6'b010000, 6'b010010};
`ifdef SIGNED_MULDIV_EN
    legal.push_back(6'b011000);
    legal.push_back(6'b011010);
`endif

    reset = 1'b1;
    applyStimulus(2'b00, 6'b000000, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("reset_stall", 64'(Stall), 64'd0);
    checkOutput("reset_divbyzero", 64'(DivByZero), 64'd0);
    reset = 1'b0;
    applyStimulus(2'b10, 6'b010000, 32'h0, 32'h0, 1'b1);
    checkOutput("reset_hi", 64'(HiLoOut), 64'd0);
    applyStimulus(2'b10, 6'b010010, 32'h0, 32'h0, 1'b1);
    checkOutput("reset_lo", 64'(HiLoOut), 64'd0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].aluop, vecs[i].funct, 32'h0, 32'h0, 1'b0);
      checkOutput($sformatf("dec_ctrl_%0d", i), 64'(ALUControl), 64'(vecs[i].ctrl));
      checkOutput($sformatf("dec_ill_%0d", i), 64'(Illegal), 64'(vecs[i].ill));
    end

    for (int f = 0; f < 64; f++) begin
      is_legal = 1'b0;
      foreach (legal[k]) if (legal[k] == 6'(f)) is_legal = 1'b1;
      applyStimulus(2'b10, 6'(f), 32'h0, 32'h0, 1'b0);
      checkOutput($sformatf("sweep_ill_%02h", f), 64'(Illegal), 64'(!is_legal));
    end

    applyStimulus(2'b10, 6'b011001, 32'd3, 32'd4, 1'b0);
    checkOutput("invalid_no_stall", 64'(Stall), 64'd0);
    tick();
    checkOutput("invalid_no_start", 64'(Stall), 64'd0);

    runOp("divu_100_7", 6'b011011, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0, 6'b010000);
    runOp("divu_5_0", 6'b011011, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1, 1'b1, 6'b011011);
    runOp("multu_ff_2", 6'b011001, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 33, 1'b0, 6'b011001);

    // Abort a MULTU at compute cycle 10; HI/LO hold nonzero values beforehand.
    applyStimulus(2'b10, 6'b011001, 32'h1234, 32'h5678, 1'b1);
    for (int c = 0; c < 10; c++) tick();
    InstrValid = 1'b0;
    #1;
    checkOutput("inflight_stall_persists", 64'(Stall), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("abort_stall", 64'(Stall), 64'd0);
    applyStimulus(2'b10, 6'b010000, 32'h0, 32'h0, 1'b1);
    checkOutput("abort_idle", 64'(Stall), 64'd0);
    checkOutput("abort_hi", 64'(HiLoOut), 64'd0);
    applyStimulus(2'b10, 6'b010010, 32'h0, 32'h0, 1'b1);
    checkOutput("abort_lo", 64'(HiLoOut), 64'd0);
    tick();

`ifdef SIGNED_MULDIV_EN
    runOp("div_m7_2", 6'b011010, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0, 6'b011010);
    runOp("mult_m3_4", 6'b011000, -32'sd3, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFF4, 33, 1'b0, 6'b011000);
`else
    applyStimulus(2'b10, 6'b011000, -32'sd3, 32'd4, 1'b1);
    checkOutput("mult_illegal", 64'(Illegal), 64'd1);
    checkOutput("mult_no_stall", 64'(Stall), 64'd0);
    tick();
    checkOutput("mult_no_start", 64'(Stall), 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
